// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780-style LCD read transaction engine (single read or busy-flag poll)
//
// Purpose:
//   Performs one LCD read cycle (RS/RW setup, EN strobe, hold) and returns the
//   byte seen on LCD_D_IN while EN was high. In poll mode it repeats the read
//   with RS=0 while the busy flag (bit 7) is set, up to MAX_POLLS reads, and
//   reports a timeout if the display is still busy at the end.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   clk_en    in   clock enable; all state and outputs hold while low
//   start     in   one-cycle request, accepted only in IDLE
//   dataa     in   [0] register select, [1] poll mode, rest ignored
//   datab     in   ignored
//   result    out  {23'b0, timeout, byte}; updated on done, held afterwards
//   done      out  one-cycle completion pulse
//   busy      out  high whenever a transaction is in flight
//   LCD_RS    out  register select to the display
//   LCD_RW    out  1 while a read is in progress
//   LCD_EN    out  enable strobe, derived from the cycle counter
//   LCD_D_IN  in   display data bus, read direction

module lcd_reader #(
    parameter int T_AS      = 3,
    parameter int T_PW      = 25,
    parameter int T_H       = 3,
    parameter int MAX_POLLS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_EN,
    input  logic [7:0]  LCD_D_IN
);

    // Poll counter holds values up to MAX_POLLS-1; one spare bit keeps the
    // compare unsigned-safe for any parameter value.
    localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) + 1 : 1;

    localparam logic [15:0]   LAST_AS    = 16'(T_AS - 1);
    localparam logic [15:0]   LAST_PW    = 16'(T_PW - 1);
    localparam logic [15:0]   LAST_H     = 16'(T_H - 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HIGH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [15:0]   r_cnt;
    logic [PW-1:0] r_poll_cnt;
    logic          r_poll;
    logic [7:0]    r_byte;

    logic w_cnt_last;
    logic w_repoll;
    logic w_timeout_exit;
    logic w_unused_bits;

    // Operand bits that carry no meaning for this instruction.
    assign w_unused_bits = ^{datab, dataa[31:2]};

    // Shared counter: flags the last enabled cycle of the current timed state.
    always_comb begin
        w_cnt_last = 1'b0;
        case (r_state)
            S_SETUP:   w_cnt_last = (r_cnt == LAST_AS);
            S_EN_HIGH: w_cnt_last = (r_cnt == LAST_PW);
            S_HOLD:    w_cnt_last = (r_cnt == LAST_H);
            default:   w_cnt_last = 1'b0;
        endcase
    end

    // Display still busy after this read: either try again or give up.
    assign w_timeout_exit = r_poll && r_byte[7];
    assign w_repoll       = w_timeout_exit && (r_poll_cnt < POLL_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_poll_cnt <= '0;
            r_poll     <= 1'b0;
            r_byte     <= 8'd0;
            result     <= 32'd0;
            done       <= 1'b0;
            busy       <= 1'b0;
            LCD_EN     <= 1'b0;
            LCD_RW     <= 1'b0;
            LCD_RS     <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_poll     <= dataa[1];
                        // Busy-flag polling always reads the instruction register.
                        LCD_RS     <= dataa[0] & ~dataa[1];
                        LCD_RW     <= 1'b1;
                        LCD_EN     <= 1'b0;
                        busy       <= 1'b1;
                        r_cnt      <= 16'd0;
                        r_poll_cnt <= '0;
                        r_state    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_cnt_last) begin
                        r_cnt   <= 16'd0;
                        LCD_EN  <= 1'b1;
                        r_state <= S_EN_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_EN_HIGH: begin
                    if (w_cnt_last) begin
                        // Capture on the final EN-high cycle so the display has
                        // had the full strobe width to drive the bus.
                        r_cnt   <= 16'd0;
                        r_byte  <= LCD_D_IN;
                        LCD_EN  <= 1'b0;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_HOLD: begin
                    if (w_cnt_last) begin
                        r_cnt <= 16'd0;
                        if (w_repoll) begin
                            r_poll_cnt <= r_poll_cnt + PW'(1);
                            r_state    <= S_SETUP;
                        end else begin
                            // Timeout flag is recomputed per transaction, so a
                            // new start always begins with it clear.
                            result  <= {23'd0, w_timeout_exit, r_byte};
                            done    <= 1'b1;
                            LCD_RW  <= 1'b0;
                            LCD_RS  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter T_AS, default 3, address setup: clk_en cycles with RS/RW valid and EN low before EN rises.
REQ-002 Parameter T_PW, default 25, EN high width in clk_en cycles.
REQ-003 Parameter T_H, default 3, EN low hold after EN falls, before the next EN or done.
REQ-004 Parameter MAX_POLLS, default 1024, busy-flag reads allowed in poll mode before timeout.
REQ-005 clk  in  1  single system clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clk_en  in  1  custom-instruction clock enable; FSM, counters and outputs hold when low.
REQ-008 start  in  1  one-cycle request; sampled only in IDLE with clk_en=1.
REQ-009 dataa  in  32  bit0 = register select (0: BF/address, 1: DDRAM/CGRAM data); bit1 = poll mode; bits 31:2 ignored.
REQ-010 datab  in  32  unused; ignored.
REQ-011 result  out  32  {23'b0, timeout, byte[7:0]}; valid while done=1, holds value until next done.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high in every state except IDLE; top level uses it to give this block the LCD pins.
REQ-014 LCD_RS  out  1  register select driven to the display.
REQ-015 LCD_RW  out  1  1 during a read transaction, 0 otherwise.
REQ-016 LCD_EN  out  1  display enable strobe, generated from counters, never from clk directly.
REQ-017 LCD_D_IN  in  8  display data bus, read direction.

Function
REQ-018 States: IDLE, SETUP, EN_HIGH, HOLD, DONE; one state register plus one shared 16-bit cycle counter and one poll counter.
REQ-019 IDLE: when start=1 and clk_en=1, latch dataa[1:0], clear counters and enter SETUP; LCD_RS = latched bit0 AND NOT bit1 (poll mode forces RS=0), LCD_RW=1.
REQ-020 SETUP: EN=0 for exactly T_AS clk_en cycles, then enter EN_HIGH.
REQ-021 EN_HIGH: EN=1 for exactly T_PW clk_en cycles; LCD_D_IN is registered into the byte register on the last EN_HIGH cycle; then enter HOLD.
REQ-022 HOLD: EN=0, RW/RS unchanged for T_H cycles; then:
  - if poll mode and byte[7]=1 and poll count < MAX_POLLS-1: increment poll count, go to SETUP;
  - otherwise go to DONE.
REQ-023 Timeout flag set when poll mode exits with byte[7]=1; cleared on every new start.
REQ-024 DONE: done=1 and result updated for exactly one clk_en cycle; LCD_RW=0 and LCD_RS=0; then return to IDLE.
REQ-025 Single-read latency: done high exactly T_AS+T_PW+T_H+1 clk_en cycles after the accepted start cycle (32 with defaults).
REQ-026 Poll latency: (N-1)*(T_AS+T_PW+T_H) plus the single-read latency, where N = number of reads performed.
REQ-027 start while busy=1 is ignored; no queuing.
REQ-028 start and reset in the same cycle: reset wins; the start is lost.
REQ-029 clk_en=0 mid-transaction freezes all state and outputs, including EN level; counting resumes where it stopped.
REQ-030 The block never drives LCD_D; the top level tri-states the bus while busy=1.

Reset
REQ-031 On reset=1 at a clk edge: state=IDLE, counters=0, byte=0, timeout=0, result=0, done=0, busy=0, LCD_EN=0, LCD_RW=0, LCD_RS=0.
REQ-032 Reset mid-transaction drops EN at the next edge, produces no done pulse, and the next start runs a full transaction.

Verification
REQ-033 Data read: dataa=1, start, LCD_D_IN=8'h41 during EN high -> RS=1, RW=1, EN high 25 cycles; done at cycle 32; result=32'h00000041.
REQ-034 Poll, not busy: dataa=2, LCD_D_IN=8'h05 -> one read with RS=0; done at cycle 32; result=32'h00000005.
REQ-035 Poll, busy for 3 reads: LCD_D_IN=8'h85 for 3 reads, then 8'h06 -> 4 EN pulses; done at cycle 3*31+32=125; result=32'h00000006.
REQ-036 Poll timeout: MAX_POLLS=4, LCD_D_IN=8'hFF -> 4 EN pulses; result=32'h000001FF.
REQ-037 Robustness:
  - clk_en low 10 cycles inside EN_HIGH -> EN high width stays 25 enabled cycles; done at cycle 42.
  - start issued while busy -> ignored.
  - reset at cycle 15 -> EN=0, RW=0 next edge; no done pulse.
